// File: rtl/response_push_engine.sv
// rtl/response_push_engine.sv - pushes P2A completions into the AXI slave B (CPL) and R (CPLD) FIFOs
// Optional cut-through push mode: define RESPONSE_PUSH_CUT_THROUGH_EN (default is store-and-forward).
module response_push_engine #(
  parameter  int BEAT_DW      = 32,
  parameter  int SB_W         = 9,
  parameter  int R_FIFO_DEPTH = 16,
  localparam int DATA_W       = 32 * BEAT_DW,
  localparam int AW           = $clog2(R_FIFO_DEPTH),
  localparam int BCNT_W       = $clog2(1024 / BEAT_DW) + 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [1:0]               cpl_type,
  input  logic [9:0]               cpl_length,
  input  logic [SB_W-1:0]          cpl_sb,
  input  logic [DATA_W-1:0]        cpl_data,
  output logic                     cpl_grant,
  output logic                     cpl_command,
  input  logic                     b_full,
  output logic                     b_wr_en,
  output logic [SB_W-1:0]          b_wr_data,
  input  logic [AW:0]              r_available,
  output logic                     r_wr_en,
  output logic [SB_W+DATA_W:0]     r_wr_data,
  output logic                     busy
);

  localparam int BEAT_SH = $clog2(BEAT_DW);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCNT_W-1:0]   r_remaining;
  logic [BCNT_W-1:0]   w_remaining_nxt;

  logic [10:0]         w_len;
  logic [10:0]         w_beats;
  logic                w_start_ok;
  logic                w_beat_ok;
  logic                w_grant;
  logic                w_cmd;
  logic                w_bwe;
  logic                w_rwe;
  logic                w_rlast;

  // Length 0 encodes 1024 DW; 11 bits hold 1024 + BEAT_DW - 1 without overflow.
  assign w_len   = (cpl_length == 10'd0) ? 11'd1024 : {1'b0, cpl_length};
  assign w_beats = (w_len + 11'(BEAT_DW - 1)) >> BEAT_SH;

`ifdef RESPONSE_PUSH_CUT_THROUGH_EN
  assign w_start_ok = (r_available != '0);
  assign w_beat_ok  = (r_available != '0);
`else
  // The whole burst is reserved up front, so a started burst never stalls.
  assign w_start_ok = (11'(r_available) >= w_beats);
  assign w_beat_ok  = 1'b1;
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_grant         = 1'b0;
    w_cmd           = 1'b0;
    w_bwe           = 1'b0;
    w_rwe           = 1'b0;
    w_rlast         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpl_type == 2'b01) begin
          if (!b_full) begin
            w_bwe   = 1'b1;
            w_grant = 1'b1;
          end
        end else if (cpl_type == 2'b10) begin
          if (w_start_ok) begin
            w_rwe           = 1'b1;
            w_grant         = 1'b1;
            w_cmd           = 1'b1;
            w_rlast         = (w_beats == 11'd1);
            w_remaining_nxt = BCNT_W'(w_beats - 11'd1);
            if (w_beats != 11'd1) begin
              w_state_nxt = S_BURST;
            end
          end
        end
      end
      S_BURST: begin
        // Header inputs and b_full are ignored here; CPLs wait for the burst to end.
        if (w_beat_ok) begin
          w_rwe           = 1'b1;
          w_cmd           = 1'b1;
          w_rlast         = (r_remaining == BCNT_W'(1));
          w_remaining_nxt = r_remaining - BCNT_W'(1);
          if (r_remaining == BCNT_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Reset forces every output low at once, even with a header still presented.
  assign cpl_grant   = arst & w_grant;
  assign cpl_command = arst & w_cmd;
  assign b_wr_en     = arst & w_bwe;
  assign r_wr_en     = arst & w_rwe;
  assign busy        = arst & (r_state == S_BURST);
  assign b_wr_data   = b_wr_en ? cpl_sb : '0;
  assign r_wr_data   = r_wr_en ? {cpl_sb, cpl_data, w_rlast} : '0;

endmodule

// File: tb/tb_response_push_engine.sv
// tb/tb_response_push_engine.sv - directed self-checking bench for response_push_engine
// Configured with BEAT_DW=32, R_FIFO_DEPTH=32 so a length-0 CPLD is a 32-beat burst.
module tb_response_push_engine;

  localparam int BEAT_DW      = 32;
  localparam int SB_W         = 9;
  localparam int R_FIFO_DEPTH = 32;
  localparam int DATA_W       = 32 * BEAT_DW;
  localparam int AW           = $clog2(R_FIFO_DEPTH);

  // {grant, command, b_wr_en, r_wr_en, rlast, busy}
  localparam logic [5:0] O_NONE      = 6'b000000;
  localparam logic [5:0] O_CPL       = 6'b101000;
  localparam logic [5:0] O_HEAD      = 6'b110100;
  localparam logic [5:0] O_HEAD_LAST = 6'b110110;
  localparam logic [5:0] O_BEAT      = 6'b010101;
  localparam logic [5:0] O_BEAT_LAST = 6'b010111;
  localparam logic [5:0] O_STALL     = 6'b000001;

  logic                  clk = 1'b0;
  logic                  arst;
  logic [1:0]            cpl_type;
  logic [9:0]            cpl_length;
  logic [SB_W-1:0]       cpl_sb;
  logic [DATA_W-1:0]     cpl_data;
  logic                  cpl_grant;
  logic                  cpl_command;
  logic                  b_full;
  logic                  b_wr_en;
  logic [SB_W-1:0]       b_wr_data;
  logic [AW:0]           r_available;
  logic                  r_wr_en;
  logic [SB_W+DATA_W:0]  r_wr_data;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  response_push_engine #(
    .BEAT_DW      (BEAT_DW),
    .SB_W         (SB_W),
    .R_FIFO_DEPTH (R_FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .cpl_type    (cpl_type),
    .cpl_length  (cpl_length),
    .cpl_sb      (cpl_sb),
    .cpl_data    (cpl_data),
    .cpl_grant   (cpl_grant),
    .cpl_command (cpl_command),
    .b_full      (b_full),
    .b_wr_en     (b_wr_en),
    .b_wr_data   (b_wr_data),
    .r_available (r_available),
    .r_wr_en     (r_wr_en),
    .r_wr_data   (r_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] t, input logic [9:0] len, input logic [SB_W-1:0] sb,
                       input logic [63:0] d, input logic bf, input logic [AW:0] ra);
    cpl_type        = t;
    cpl_length      = len;
    cpl_sb          = sb;
    cpl_data        = '0;
    cpl_data[63:0]  = d;
    b_full          = bf;
    r_available     = ra;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {cpl_grant, cpl_command, b_wr_en, r_wr_en, r_wr_data[0], busy};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst = 1'b0;
    drive(2'b10, 10'd32, 9'h1A5, 64'h1, 1'b0, 6'd32);
    #3;
    chk_o("rst_cpld", O_NONE);
    drive(2'b01, 10'd0, 9'h1A5, 64'h1, 1'b0, 6'd32);
    #1;
    chk_o("rst_cpl", O_NONE);
    chk_v("rst_bdata", 64'(b_wr_data), 64'h0);
    chk_v("rst_rdata", r_wr_data[63:0], 64'h0);

    repeat (2) @(posedge clk);
    #1;
    arst = 1'b1;
    drive(2'b01, 10'd0, 9'h1A5, 64'h0, 1'b0, 6'd32);
    #1;
    chk_o("cpl", O_CPL);
    chk_v("cpl_bdata", 64'(b_wr_data), 64'h1A5);

    nxt(); drive(2'b01, 10'd0, 9'h0F0, 64'h0, 1'b1, 6'd32); #1;
    chk_o("cpl_bfull", O_NONE);
    nxt(); drive(2'b01, 10'd0, 9'h0F0, 64'h0, 1'b0, 6'd32); #1;
    chk_o("cpl_bfree", O_CPL);
    chk_v("cpl_bfree_data", 64'(b_wr_data), 64'h0F0);

    nxt(); drive(2'b11, 10'd32, 9'h0F0, 64'h0, 1'b0, 6'd32); #1;
    chk_o("reserved", O_NONE);

    nxt(); drive(2'b10, 10'd32, 9'h0C3, 64'h1111, 1'b0, 6'd32); #1;
    chk_o("cpld1", O_HEAD_LAST);
    chk_v("cpld1_data", r_wr_data[64:1], 64'h1111);
    chk_v("cpld1_sb", 64'(r_wr_data[DATA_W+SB_W:DATA_W+1]), 64'h0C3);
    nxt(); drive(2'b00, 10'd0, 9'h0, 64'h0, 1'b0, 6'd32); #1;
    chk_o("cpld1_idle", O_NONE);

    nxt(); drive(2'b10, 10'd70, 9'h033, 64'hA1, 1'b0, 6'd32); #1;
    chk_o("b70_1", O_HEAD);
    nxt(); drive(2'b10, 10'd70, 9'h033, 64'hA2, 1'b0, 6'd32); #1;
    chk_o("b70_2", O_BEAT);
    chk_v("b70_2_data", r_wr_data[64:1], 64'hA2);
    nxt(); drive(2'b10, 10'd70, 9'h033, 64'hA3, 1'b0, 6'd32); #1;
    chk_o("b70_3", O_BEAT_LAST);
    chk_v("b70_3_sb", 64'(r_wr_data[DATA_W+SB_W:DATA_W+1]), 64'h033);
    nxt(); drive(2'b01, 10'd0, 9'h055, 64'h0, 1'b0, 6'd32); #1;
    chk_o("b70_cpl", O_CPL);
    chk_v("b70_cpl_data", 64'(b_wr_data), 64'h055);

`ifndef RESPONSE_PUSH_CUT_THROUGH_EN
    nxt(); drive(2'b10, 10'd0, 9'h1FF, 64'h1, 1'b0, 6'd31); #1;
    chk_o("sf_short", O_NONE);
    nxt(); drive(2'b10, 10'd0, 9'h1FF, 64'h1, 1'b0, 6'd32); #1;
    chk_o("sf_start", O_HEAD);
    for (int i = 2; i <= 32; i++) begin
      nxt(); drive(2'b10, 10'd0, 9'h1FF, 64'(i), 1'b0, 6'd0); #1;
      chk_o($sformatf("sf_beat%0d", i), (i == 32) ? O_BEAT_LAST : O_BEAT);
    end
    nxt(); drive(2'b00, 10'd0, 9'h0, 64'h0, 1'b0, 6'd0); #1;
    chk_o("sf_done", O_NONE);
`else
    nxt(); drive(2'b10, 10'd256, 9'h1E1, 64'h1, 1'b0, 6'd0); #1;
    chk_o("ct_empty", O_NONE);
    nxt(); drive(2'b10, 10'd256, 9'h1E1, 64'h1, 1'b0, 6'd5); #1;
    chk_o("ct_start", O_HEAD);
    for (int i = 2; i <= 3; i++) begin
      nxt(); drive(2'b10, 10'd256, 9'h1E1, 64'(i), 1'b0, 6'd4); #1;
      chk_o($sformatf("ct_beat%0d", i), O_BEAT);
    end
    for (int i = 0; i < 2; i++) begin
      nxt(); drive(2'b10, 10'd256, 9'h1E1, 64'h4, 1'b0, 6'd0); #1;
      chk_o($sformatf("ct_stall%0d", i), O_STALL);
    end
    for (int i = 4; i <= 8; i++) begin
      nxt(); drive(2'b10, 10'd256, 9'h1E1, 64'(i), 1'b0, 6'd3); #1;
      chk_o($sformatf("ct_beat%0d", i), (i == 8) ? O_BEAT_LAST : O_BEAT);
      chk_v($sformatf("ct_data%0d", i), r_wr_data[64:1], 64'(i));
    end
    nxt(); drive(2'b00, 10'd0, 9'h0, 64'h0, 1'b0, 6'd3); #1;
    chk_o("ct_done", O_NONE);
`endif

    nxt(); drive(2'b10, 10'd128, 9'h0AA, 64'hB1, 1'b0, 6'd32); #1;
    chk_o("mid_1", O_HEAD);
    nxt(); drive(2'b10, 10'd128, 9'h0AA, 64'hB2, 1'b0, 6'd32); #1;
    chk_o("mid_2", O_BEAT);
    arst = 1'b0;
    #1;
    chk_o("mid_arst", O_NONE);
    chk_v("mid_arst_rdata", r_wr_data[63:0], 64'h0);
    nxt();
    arst = 1'b1;
    drive(2'b00, 10'd0, 9'h0, 64'h0, 1'b0, 6'd32); #1;
    chk_o("post_rst_idle", O_NONE);
    nxt(); drive(2'b01, 10'd0, 9'h12A, 64'h0, 1'b0, 6'd32); #1;
    chk_o("post_rst_cpl", O_CPL);
    chk_v("post_rst_bdata", 64'(b_wr_data), 64'h12A);

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
